// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue: queue entry layout,
// fetch FSM states and the sequential pc step.
package fetch_pkg;

    localparam int unsigned FQ_WIDTH = 32;
    localparam logic [FQ_WIDTH-1:0] FQ_PC_STEP = 32'd4;

    typedef struct packed {
        logic [FQ_WIDTH-1:0] ins;
        logic [FQ_WIDTH-1:0] pc;
        logic [FQ_WIDTH-1:0] pc_plus4;
    } fq_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fq_state_e;

    function automatic logic [FQ_WIDTH-1:0] fq_next_pc(input logic [FQ_WIDTH-1:0] pc);
        return pc + FQ_PC_STEP;
    endfunction

endpackage

// File: rtl/fq_fifo.sv
// DEPTH-entry FIFO of fetched instructions with push/pop/flush; the head is read
// combinationally from storage and reads as zero while the FIFO is empty.
module fq_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  fq_entry_t     i_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output fq_entry_t     o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    fq_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));

    // A flush suppresses both sides; a push into a full FIFO is legal only alongside a pop.
    always_comb begin
        w_do_push = 1'b0;
        w_do_pop  = 1'b0;
        if (i_flush) begin
            w_do_push = 1'b0;
            w_do_pop  = 1'b0;
        end else begin
            w_do_pop  = i_pop && !o_empty;
            w_do_push = i_push && (!o_full || w_do_pop);
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Head read port, forced to zero when nothing is buffered.
    always_comb begin
        o_head = '0;
        if (o_empty) begin
            o_head = '0;
        end else begin
            o_head = r_mem[r_rd_ptr];
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential req/ack fetches into fq_fifo, redirect flush
// with stale-response drop. Optional perf counters under `FETCH_QUEUE_PERF_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned      WIDTH    = FQ_WIDTH,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0,
    localparam int unsigned     CW       = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [WIDTH-1:0] imem_rdata_i,
    output logic             dec_valid_o,
    input  logic             dec_ready_i,
    output logic [WIDTH-1:0] dec_ins_o,
    output logic [WIDTH-1:0] dec_pc_o,
    output logic [WIDTH-1:0] dec_pc_plus4_o
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]      perf_flush_o,
    output logic [31:0]      perf_stall_o
`endif
);

    fq_state_e        r_state;
    fq_state_e        w_state_nxt;
    logic [WIDTH-1:0] r_fetch_pc;
    logic [WIDTH-1:0] w_fetch_pc_nxt;
    logic [WIDTH-1:0] r_drop_addr;
    logic [WIDTH-1:0] w_drop_addr_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    fq_entry_t        w_entry;
    fq_entry_t        w_head;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_count_after;

    assign w_pop         = dec_ready_i && !w_empty;
    assign w_count_after = w_count + CW'(1) - CW'(w_pop);
    assign w_entry       = '{ins: imem_rdata_i, pc: r_fetch_pc, pc_plus4: fq_next_pc(r_fetch_pc)};

    fq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Fetch FSM state and address registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_fetch_pc  <= RESET_PC;
            r_drop_addr <= RESET_PC;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_drop_addr <= w_drop_addr_nxt;
        end
    end

    // Next-state logic; DROP keeps the abandoned address on the bus until memory acks it.
    always_comb begin
        w_state_nxt     = r_state;
        w_fetch_pc_nxt  = r_fetch_pc;
        w_drop_addr_nxt = r_drop_addr;
        w_push          = 1'b0;
        w_flush         = 1'b0;
        case (r_state)
            IDLE: begin
                if (redirect_i) begin
                    w_flush        = 1'b1;
                    w_fetch_pc_nxt = redirect_pc_i;
                    w_state_nxt    = REQ;
                end else if (w_count < CW'(DEPTH)) begin
                    w_state_nxt = REQ;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                if (redirect_i) begin
                    w_flush        = 1'b1;
                    w_fetch_pc_nxt = redirect_pc_i;
                    if (imem_ack_i) begin
                        w_state_nxt = REQ;
                    end else begin
                        w_state_nxt     = DROP;
                        w_drop_addr_nxt = r_fetch_pc;
                    end
                end else if (imem_ack_i) begin
                    w_push         = 1'b1;
                    w_fetch_pc_nxt = fq_next_pc(r_fetch_pc);
                    w_state_nxt    = (w_count_after < CW'(DEPTH)) ? REQ : IDLE;
                end else begin
                    w_state_nxt = REQ;
                end
            end
            DROP: begin
                if (redirect_i) begin
                    w_flush        = 1'b1;
                    w_fetch_pc_nxt = redirect_pc_i;
                    w_state_nxt    = imem_ack_i ? REQ : DROP;
                end else if (imem_ack_i) begin
                    w_state_nxt = REQ;
                end else begin
                    w_state_nxt = DROP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign imem_req_o     = (r_state != IDLE);
    assign imem_addr_o    = (r_state == DROP) ? r_drop_addr : r_fetch_pc;
    assign dec_valid_o    = !w_empty;
    assign dec_ins_o      = w_head.ins;
    assign dec_pc_o       = w_head.pc;
    assign dec_pc_plus4_o = w_head.pc_plus4;

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_stall;

    // Saturating redirect and decode-starvation counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_flush <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            if (redirect_i && (r_perf_flush != 32'hFFFF_FFFF)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
            if (dec_ready_i && !dec_valid_o && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_flush_o = r_perf_flush;
    assign perf_stall_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: random memory latency, decode backpressure and
// redirects; expected decode stream derived from the pc-sequence rules.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] dec_ins_o;
    logic [31:0] dec_pc_o;
    logic [31:0] dec_pc_plus4_o;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_flush_o;
    logic [31:0] perf_stall_o;
`endif

    fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_rdata_i   (imem_rdata_i),
        .dec_valid_o    (dec_valid_o),
        .dec_ready_i    (dec_ready_i),
        .dec_ins_o      (dec_ins_o),
        .dec_pc_o       (dec_pc_o),
        .dec_pc_plus4_o (dec_pc_plus4_o)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_flush_o   (perf_flush_o),
        .perf_stall_o   (perf_stall_o)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          ready_mode = 1;   // 0: never ready, 1: always ready, 2: random
    int          lat_max = 0;
    bit          redir_en = 1'b0;
    bit          mem_hold = 1'b0;
    int          flush_cnt = 0;
    int          stall_cnt = 0;
    int          redir_seq = 0;
    logic [31:0] next_fetch = 32'h0;

    function automatic logic [31:0] ins_of(input logic [31:0] a);
        return (a ^ 32'h5A5A_C3C3) + {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: memory responder, redirect generator, decode backpressure and scoreboard push.
    initial begin
        bit          busy;
        int          lat_left;
        bit          ack;
        bit          prev_req;
        bit          prev_ack;
        logic [31:0] prev_addr;
        logic [31:0] tgt;
        busy = 1'b0; lat_left = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                redirect_i   = 1'b0;
                imem_ack_i   = 1'b0;
                busy         = 1'b0;
                prev_req     = 1'b0;
                exp_q.delete();
                next_fetch   = 32'h0;
                flush_cnt    = 0;
                stall_cnt    = 0;
                dec_ready_i  = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
            end else begin
                if (prev_req && !prev_ack && imem_req_o) begin
                    chk("addr_stable", imem_addr_o, prev_addr);
                end
                redirect_i = 1'b0;
                tgt = 32'h0;
                if (redir_en && ($urandom_range(0, 11) == 0)) begin
                    redir_seq++;
                    tgt = 32'h1000 * 32'(redir_seq) + 32'(4 * $urandom_range(0, 63));
                    redirect_i    = 1'b1;
                    redirect_pc_i = tgt;
                    flush_cnt++;
                end
                ack = 1'b0;
                if (!imem_req_o) begin
                    busy = 1'b0;
                end else if (!mem_hold) begin
                    if (!busy) begin
                        busy     = 1'b1;
                        lat_left = $urandom_range(0, lat_max);
                    end
                    if (lat_left == 0) begin
                        ack  = 1'b1;
                        busy = 1'b0;
                    end else begin
                        lat_left--;
                    end
                end
                imem_ack_i   = ack;
                imem_rdata_i = ack ? ins_of(imem_addr_o) : $urandom;
                if (redirect_i) begin
                    exp_q.delete();
                    next_fetch = tgt;
                end else if (ack && (imem_addr_o == next_fetch)) begin
                    exp_q.push_back('{pc: next_fetch, ins: ins_of(next_fetch)});
                    next_fetch = next_fetch + 32'd4;
                end
                dec_ready_i = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
                if (dec_ready_i && !dec_valid_o) begin
                    stall_cnt++;
                end
                prev_req  = imem_req_o;
                prev_ack  = ack;
                prev_addr = imem_addr_o;
            end
        end
    end

    // Monitor: compares every accepted decode handshake against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && dec_valid_o && dec_ready_i && !redirect_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_deq got=%h exp=none", dec_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("deq_pc", dec_pc_o, e.pc);
                    chk("deq_pc4", dec_pc_plus4_o, e.pc + 32'd4);
                    chk("deq_ins", dec_ins_o, e.ins);
                end
            end else if (rst && !dec_valid_o) begin
                chk("empty_data", dec_pc_o | dec_ins_o | dec_pc_plus4_o, 32'h0);
            end
        end
    end

    initial begin
        rst = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        imem_ack_i = 1'b0; imem_rdata_i = 32'h0; dec_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(imem_req_o), 32'h0);
        chk("rst_valid", 32'(dec_valid_o), 32'h0);
        chk("rst_pc", dec_pc_o, 32'h0);

        // zero-latency memory, decode always ready: pc 0 at cycle 2, 4 at cycle 3
        ready_mode = 1; lat_max = 0;
        rst = 1'b1;
        @(negedge clk);
        chk("c1_valid", 32'(dec_valid_o), 32'h0);
        chk("c1_req", 32'(imem_req_o), 32'h1);
        @(negedge clk);
        chk("c2_valid", 32'(dec_valid_o), 32'h1);
        chk("c2_pc", dec_pc_o, 32'h0);
        @(negedge clk);
        chk("c3_pc", dec_pc_o, 32'h4);
        repeat (20) @(negedge clk);

        // decode stalled: exactly DEPTH fetches then the request drops
        rst = 1'b0; ready_mode = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("full_req", 32'(imem_req_o), 32'h0);
        chk("full_valid", 32'(dec_valid_o), 32'h1);
        chk("full_head", dec_pc_o, 32'h0);
        chk("full_cnt", 32'(exp_q.size()), 32'd4);
        ready_mode = 1;
        repeat (20) @(negedge clk);

        // random latency, backpressure and redirects
        lat_max = 3; ready_mode = 2; redir_en = 1'b1;
        repeat (4000) @(negedge clk);
        redir_en = 1'b0; ready_mode = 0;
        repeat (3) @(negedge clk);
`ifdef FETCH_QUEUE_PERF_EN
        chk("perf_flush", perf_flush_o, 32'(flush_cnt));
        chk("perf_stall", perf_stall_o, 32'(stall_cnt));
`endif

        // stop memory and drain: every acked in-stream word must reach decode
        mem_hold = 1'b1; ready_mode = 1;
        repeat (20) @(negedge clk);
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("drain_valid", 32'(dec_valid_o), 32'h0);

        // reset while a request is outstanding, then restart from RESET_PC
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst2_req", 32'(imem_req_o), 32'h0);
`ifdef FETCH_QUEUE_PERF_EN
        chk("perf_flush_rst", perf_flush_o, 32'h0);
        chk("perf_stall_rst", perf_stall_o, 32'h0);
`endif
        mem_hold = 1'b0; lat_max = 2;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst2_stream", next_fetch & 32'hFFFF_F000, 32'h0);
        repeat (15) @(negedge clk);
        chk("rst2_progress", 32'(next_fetch > 32'h8), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
